nco_sweep_ctrl: RTL and testbench

Sequencer that drives the phase-increment input of the LUT sine NCO to produce stepped frequency sweeps: single ramp, repeating sawtooth, or triangle.
Config is latched on a start handshake. Each step holds for a programmable number of sample-clock ticks. The block also gates the NCO sample enable so the NCO phase accumulator only advances while a sweep runs.
Sits between the register/control interface and the NCO instance in the carrier-generation path.

---
 rtl/nco_sweep_ctrl.sv | 125 ++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: steps the NCO phase increment through single, sawtooth or triangle sweeps and gates the NCO sample enable
module nco_sweep_ctrl #(
  parameter int PB = 64,
  parameter int NW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_clock_ce,
  input  logic          start,
  input  logic          abort,
  input  logic [PB-1:0] cfg_start_inc,
  input  logic [PB-1:0] cfg_step_inc,
  input  logic [NW-1:0] cfg_num_steps,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [1:0]    cfg_mode,
  output logic [PB-1:0] phase_inc,
  output logic          nco_ce,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] step_idx,
  output logic          sweep_wrap
);
  typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN} state_t;
  state_t state, state_n;
  logic [PB-1:0] phase_n, step_r, step_n, base_r, base_n;
  logic [NW-1:0] idx_n, n_r, n_n;
  logic [DW-1:0] dwell_cnt, dwell_cnt_n, dwell_r, dwell_n;
  logic [1:0] mode_r, mode_n;
  logic busy_n, done_n, wrap_n, rev, rev_n, up, last;
  assign nco_ce = sample_clock_ce & busy;
  assign up = state == RUN_UP;
  // after the first triangle reversal the shared endpoint is not revisited, so legs are one step shorter
  assign last = step_idx == n_r - NW'(1) || (rev && step_idx == n_r - NW'(2));
  always_comb begin
    state_n = state;
    phase_n = phase_inc;
    busy_n = busy;
    done_n = 1'b0;
    wrap_n = 1'b0;
    idx_n = step_idx;
    dwell_cnt_n = dwell_cnt;
    rev_n = rev;
    step_n = step_r;
    base_n = base_r;
    n_n = n_r;
    dwell_n = dwell_r;
    mode_n = mode_r;
    if (abort) begin
      state_n = IDLE;
      busy_n = 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        step_n = cfg_step_inc;
        base_n = cfg_start_inc;
        n_n = cfg_num_steps;
        dwell_n = cfg_dwell;
        mode_n = cfg_mode;
        if (cfg_num_steps == '0) done_n = 1'b1;
        else begin
          state_n = RUN_UP;
          phase_n = cfg_start_inc;
          idx_n = '0;
          dwell_cnt_n = '0;
          busy_n = 1'b1;
          rev_n = 1'b0;
        end
      end
    end else if (sample_clock_ce) begin
      if (dwell_cnt != dwell_r) dwell_cnt_n = dwell_cnt + DW'(1);
      else begin
        dwell_cnt_n = '0;
        if (!last) begin
          idx_n = step_idx + NW'(1);
          phase_n = up ? phase_inc + step_r : phase_inc - step_r;
        end else if (mode_r == 2'b10) begin
          state_n = up ? RUN_DOWN : RUN_UP;
          idx_n = '0;
          wrap_n = 1'b1;
          rev_n = 1'b1;
          phase_n = n_r == NW'(1) ? phase_inc : (up ? phase_inc - step_r : phase_inc + step_r);
        end else if (mode_r == 2'b01) begin
          phase_n = base_r;
          idx_n = '0;
          wrap_n = 1'b1;
        end else begin
          state_n = IDLE;
          busy_n = 1'b0;
          done_n = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      phase_inc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sweep_wrap <= 1'b0;
      step_idx <= '0;
      dwell_cnt <= '0;
      rev <= 1'b0;
      step_r <= '0;
      base_r <= '0;
      n_r <= '0;
      dwell_r <= '0;
      mode_r <= '0;
    end else begin
      state <= state_n;
      phase_inc <= phase_n;
      busy <= busy_n;
      done <= done_n;
      sweep_wrap <= wrap_n;
      step_idx <= idx_n;
      dwell_cnt <= dwell_cnt_n;
      rev <= rev_n;
      step_r <= step_n;
      base_r <= base_n;
      n_r <= n_n;
      dwell_r <= dwell_n;
      mode_r <= mode_n;
    end
  end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: randomized sweeps checked against an arithmetic model of the sweep sequence
module tb_nco_sweep_ctrl;
  logic clk = 1'b0, rst, sample_clock_ce, start, abort;
  logic [63:0] cfg_start_inc, cfg_step_inc, phase_inc;
  logic [15:0] cfg_num_steps, cfg_dwell, step_idx;
  logic [1:0] cfg_mode;
  logic nco_ce, busy, done, sweep_wrap;
  int checks = 0, errors = 0;

  nco_sweep_ctrl dut (
    .clk(clk), .rst(rst), .sample_clock_ce(sample_clock_ce), .start(start), .abort(abort),
    .cfg_start_inc(cfg_start_inc), .cfg_step_inc(cfg_step_inc), .cfg_num_steps(cfg_num_steps),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .phase_inc(phase_inc), .nco_ce(nco_ce),
    .busy(busy), .done(done), .step_idx(step_idx), .sweep_wrap(sweep_wrap)
  );

  always #5 clk = ~clk;

  // position of step k along the sweep, measured in steps from the start increment
  function automatic int m_pos(input logic [1:0] md, input int n, input int k);
    int p, r;
    if (md == 2'b01) return k % n;
    if (md == 2'b10) begin
      if (n == 1) return 0;
      p = 2 * (n - 1);
      r = k % p;
      return r <= n - 1 ? r : p - r;
    end
    return k < n ? k : n - 1;
  endfunction

  function automatic int m_idx(input logic [1:0] md, input int n, input int k);
    if (md == 2'b01) return k % n;
    if (md == 2'b10) return k < n ? k : (n == 1 ? 0 : (k - n) % (n - 1));
    return k < n ? k : n - 1;
  endfunction

  function automatic bit m_wrap(input logic [1:0] md, input int n, input int k);
    if (md == 2'b01) return k > 0 && k % n == 0;
    if (md == 2'b10) return n == 1 ? k > 0 : (k >= n && (k - n) % (n - 1) == 0);
    return 1'b0;
  endfunction

  task automatic scramble_cfg();
    cfg_start_inc = {$urandom, $urandom};
    cfg_step_inc = {$urandom, $urandom};
    cfg_num_steps = 16'($urandom);
    cfg_dwell = 16'($urandom);
    cfg_mode = 2'($urandom);
  endtask

  task automatic run_sweep(input logic [1:0] md, input logic [63:0] s, input logic [63:0] st,
                           input int n, input int d, input int cep, input int ncyc);
    int ticks = 0, k;
    bit running = 1, was_running, ce_now, exp_done, exp_wrap;
    logic [1:0] mm;
    logic [63:0] exp_ph;
    mm = md == 2'b11 ? 2'b00 : md;
    cfg_start_inc = s; cfg_step_inc = st; cfg_num_steps = 16'(n); cfg_dwell = 16'(d); cfg_mode = md;
    sample_clock_ce = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    scramble_cfg();
    checks += 3;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", busy); end
    if (phase_inc !== s) begin errors++; $display("FAIL start_phase got %h want %h", phase_inc, s); end
    if (step_idx !== 16'd0) begin errors++; $display("FAIL start_idx got %0d want 0", step_idx); end
    for (int c = 0; c < ncyc; c++) begin
      ce_now = cep == 0 ? 1'b1 : cep == 1 ? (c % 4 == 3) : 1'($urandom_range(0, 1));
      sample_clock_ce = ce_now;
      start = running ? 1'($urandom_range(0, 1)) : 1'b0;
      scramble_cfg();
      #1;
      checks++;
      if (nco_ce !== (ce_now & running)) begin errors++; $display("FAIL nco_ce cyc %0d got %b want %b", c, nco_ce, ce_now & running); end
      @(posedge clk); #1;
      was_running = running;
      exp_done = 0;
      if (running && ce_now) begin
        ticks++;
        if (mm == 2'b00 && ticks == n * (d + 1)) begin running = 0; exp_done = 1; end
      end
      k = ticks / (d + 1);
      exp_ph = s + st * 64'(m_pos(mm, n, k));
      exp_wrap = was_running && ce_now && ticks % (d + 1) == 0 && m_wrap(mm, n, k);
      checks += 5;
      if (busy !== running) begin errors++; $display("FAIL busy cyc %0d got %b want %b", c, busy, running); end
      if (done !== exp_done) begin errors++; $display("FAIL done cyc %0d got %b want %b", c, done, exp_done); end
      if (phase_inc !== exp_ph) begin errors++; $display("FAIL phase cyc %0d got %h want %h", c, phase_inc, exp_ph); end
      if (step_idx !== 16'(m_idx(mm, n, k))) begin errors++; $display("FAIL idx cyc %0d got %0d want %0d", c, step_idx, m_idx(mm, n, k)); end
      if (sweep_wrap !== exp_wrap) begin errors++; $display("FAIL wrap cyc %0d got %b want %b", c, sweep_wrap, exp_wrap); end
    end
    start = 0; sample_clock_ce = 0;
    if (running) begin
      abort = 1;
      @(posedge clk); #1;
      abort = 0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL cleanup_abort got %b want 0", busy); end
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; abort = 0; sample_clock_ce = 0;
    scramble_cfg();
    #12;
    checks += 4;
    if (phase_inc !== 64'd0) begin errors++; $display("FAIL rst_phase got %h want 0", phase_inc); end
    if (busy !== 1'b0 || nco_ce !== 1'b0) begin errors++; $display("FAIL rst_busy got %b/%b want 0/0", busy, nco_ce); end
    if (done !== 1'b0 || sweep_wrap !== 1'b0) begin errors++; $display("FAIL rst_pulses got %b/%b want 0/0", done, sweep_wrap); end
    if (step_idx !== 16'd0) begin errors++; $display("FAIL rst_idx got %0d want 0", step_idx); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_steps();
    logic [63:0] prev;
    prev = phase_inc;
    cfg_start_inc = 64'h1234; cfg_num_steps = 0; cfg_dwell = 0; cfg_mode = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    checks += 3;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b want 0", busy); end
    if (phase_inc !== prev) begin errors++; $display("FAIL zero_phase got %h want %h", phase_inc, prev); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after got %b/%b want 0/0", done, busy); end
  endtask

  task automatic test_abort();
    cfg_start_inc = 64'h500; cfg_step_inc = 64'h20; cfg_num_steps = 5; cfg_dwell = 0; cfg_mode = 2'b01;
    start = 1; sample_clock_ce = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (step_idx !== 16'd2) begin errors++; $display("FAIL abort_pre_idx got %0d want 2", step_idx); end
    abort = 1; start = 1;
    @(posedge clk); #1;
    abort = 0; start = 0;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
    if (phase_inc !== 64'h540) begin errors++; $display("FAIL abort_phase got %h want 540", phase_inc); end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || nco_ce !== 1'b0 || phase_inc !== 64'h540) begin errors++; $display("FAIL abort_idle got %b/%b/%h want 0/0/540", busy, nco_ce, phase_inc); end
    end
    abort = 1;
    @(posedge clk); #1;
    abort = 0; sample_clock_ce = 0;
    checks++;
    if (busy !== 1'b0 || phase_inc !== 64'h540) begin errors++; $display("FAIL abort_in_idle got %b/%h want 0/540", busy, phase_inc); end
  endtask

  task automatic test_rst_mid();
    cfg_start_inc = 64'h900; cfg_step_inc = 64'h7; cfg_num_steps = 8; cfg_dwell = 1; cfg_mode = 0;
    start = 1; sample_clock_ce = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #2 rst = 1;
    #1;
    checks += 2;
    if (busy !== 1'b0 || phase_inc !== 64'd0) begin errors++; $display("FAIL rstmid got %b/%h want 0/0", busy, phase_inc); end
    if (step_idx !== 16'd0 || nco_ce !== 1'b0) begin errors++; $display("FAIL rstmid_idx got %0d/%b want 0/0", step_idx, nco_ce); end
    @(negedge clk); rst = 0; sample_clock_ce = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      run_sweep(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(1, 5), $urandom_range(0, 3), 2, 40);
  endtask

  initial begin
    test_reset();
    run_sweep(2'b00, 64'h100, 64'h10, 4, 2, 0, 16);
    run_sweep(2'b00, 64'h100, 64'h10, 4, 2, 1, 52);
    run_sweep(2'b10, 64'h100, 64'h10, 3, 0, 0, 12);
    run_sweep(2'b01, 64'h100, 64'h10, 3, 0, 0, 10);
    run_sweep(2'b10, 64'h40, 64'h3, 1, 1, 0, 8);
    run_sweep(2'b11, 64'h8, -64'h10, 2, 0, 0, 4);
    test_zero_steps();
    test_abort();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
